// File: rtl/nest_placer.sv
// nest_placer: setup-phase placement controller sitting upstream of the nest.
// The direction keys steer a cursor, which is clamped so that the whole nest
// stays on screen. A place request probes the obstacle map at the cursor, and
// a clear site produces a one-cycle SET strobe carrying the chosen coordinates.
// Screen coordinates are used throughout, so y grows downward: key_up lowers y.
module nest_placer #(
    parameter int X_BITS   = 10,
    parameter int Y_BITS   = 9,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int RADIUS   = 8,
    parameter int MOVE_DIV = 4
) (
    input  logic              setup_clk,
    input  logic              RESET,
    input  logic              SETUP_PHASE,
    input  logic              key_up,
    input  logic              key_down,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_place,
    input  logic              obstacle_hit,
    output logic [X_BITS-1:0] cursor_x,
    output logic [Y_BITS-1:0] cursor_y,
    output logic              SET,
    output logic [X_BITS-1:0] out_x,
    output logic [Y_BITS-1:0] out_y,
    output logic              placed,
    output logic              reject
);

    typedef enum logic [2:0] {IDLE, MOVE, CHECK, COMMIT, DONE} state_t;

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [X_BITS-1:0] X_LO  = X_BITS'(RADIUS);
    localparam logic [X_BITS-1:0] X_HI  = X_BITS'(X_MAX - RADIUS);
    localparam logic [X_BITS-1:0] X_MID = X_BITS'(X_MAX / 2);
    localparam logic [Y_BITS-1:0] Y_LO  = Y_BITS'(RADIUS);
    localparam logic [Y_BITS-1:0] Y_HI  = Y_BITS'(Y_MAX - RADIUS);
    localparam logic [Y_BITS-1:0] Y_MID = Y_BITS'(Y_MAX / 2);
    localparam logic [CW-1:0]     DIV_LAST = CW'(MOVE_DIV - 1);

    state_t            state;
    logic              setup_q;
    logic              place_q;
    logic [CW-1:0]     step_cnt;
    logic [X_BITS-1:0] next_x;
    logic [Y_BITS-1:0] next_y;

    // Opposing keys cancel; a lone key moves one pixel in its direction.
    logic x_inc, x_dec, y_inc, y_dec, any_dir, setup_rise, place_rise;
    assign x_inc      = key_right & ~key_left;
    assign x_dec      = key_left  & ~key_right;
    assign y_inc      = key_down  & ~key_up;
    assign y_dec      = key_up    & ~key_down;
    assign any_dir    = key_up | key_down | key_left | key_right;
    assign setup_rise = SETUP_PHASE & ~setup_q;
    assign place_rise = key_place & ~place_q;

    // Candidate cursor for a step; compared before the add/subtract, so the
    // position saturates at the clamp bounds and can never wrap.
    always_comb begin
        next_x = cursor_x;
        next_y = cursor_y;
        if (x_inc && (cursor_x < X_HI))      next_x = cursor_x + X_BITS'(1);
        else if (x_dec && (cursor_x > X_LO)) next_x = cursor_x - X_BITS'(1);
        if (y_inc && (cursor_y < Y_HI))      next_y = cursor_y + Y_BITS'(1);
        else if (y_dec && (cursor_y > Y_LO)) next_y = cursor_y - Y_BITS'(1);
    end

    // Placement FSM; every output is a register updated here.
    always_ff @(posedge setup_clk or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            setup_q  <= 1'b0;
            place_q  <= 1'b0;
            step_cnt <= '0;
            cursor_x <= X_MID;
            cursor_y <= Y_MID;
            out_x    <= '0;
            out_y    <= '0;
            SET      <= 1'b0;
            placed   <= 1'b0;
            reject   <= 1'b0;
        end else begin
            setup_q <= SETUP_PHASE;
            place_q <= key_place;
            SET     <= 1'b0;
            reject  <= 1'b0;
            case (state)
                IDLE: begin
                    step_cnt <= '0;
                    if (setup_rise) begin
                        state    <= MOVE;
                        placed   <= 1'b0;
                        cursor_x <= X_MID;
                        cursor_y <= Y_MID;
                    end
                end
                MOVE: begin
                    if (!SETUP_PHASE) begin
                        state    <= IDLE;
                        step_cnt <= '0;
                    end else if (place_rise) begin
                        // The place edge wins over motion for this cycle.
                        state    <= CHECK;
                        step_cnt <= '0;
                    end else if (!any_dir) begin
                        step_cnt <= '0;
                    end else begin
                        // The first held cycle steps, then every MOVE_DIV cycles.
                        if (step_cnt == '0) begin
                            cursor_x <= next_x;
                            cursor_y <= next_y;
                        end
                        step_cnt <= (step_cnt == DIV_LAST) ? '0 : step_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (!SETUP_PHASE) begin
                        state <= IDLE;
                    end else if (obstacle_hit) begin
                        reject <= 1'b1;
                        state  <= MOVE;
                    end else begin
                        out_x <= cursor_x;
                        out_y <= cursor_y;
                        SET   <= 1'b1;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // The strobe always completes, even if setup has just ended.
                    placed <= 1'b1;
                    state  <= SETUP_PHASE ? DONE : IDLE;
                end
                DONE: begin
                    if (!SETUP_PHASE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
